// File: rtl/imem_responder.sv
// imem_responder: instruction fetch responder with fixed latency.
// Ports: clk/reset, req_* fetch request, resp_* response, prog_* load.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Counter holds at most LATENCY-1.
  localparam int unsigned CW =
    (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam bit ONE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   src_addr;
  logic [31:0]   src_word;
  logic          src_err;
  logic [AW-1:0] src_idx;
  logic [31:0]   prog_word;
  logic          prog_hit;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // With single-cycle latency the capture edge is the
  // accepting edge, so the live request address is used.
  assign src_addr = (state == IDLE) ? req_addr : addr_q;
  assign src_word = src_addr >> 2;
  assign src_err  = (src_addr[1:0] != 2'b00) ||
                    (src_word >= DEPTH_W);
  assign src_idx  = src_word[AW-1:0];

  assign enter_resp =
    (accept && ONE_CYCLE) ||
    (state == WAIT && cnt == CW'(1));

  // Low address bits are dropped by the shift.
  assign prog_word = prog_addr >> 2;
  assign prog_hit  = prog_word < DEPTH_W;

  // Loads are never blocked by reset or by fetch state.
  always_ff @(posedge clk) begin
    if (prog_we && prog_hit)
      mem[prog_word[AW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      resp_valid <= 1'b0;
      resp_instr <= '0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
    end else begin
      // Memory read shares the edge with any load, so a
      // same-edge write to this word is not observed.
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_addr  <= src_addr;
        resp_err   <= src_err;
        resp_instr <= src_err ? NOP_WORD : mem[src_idx];
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            cnt    <= CNT_LOAD;
            state  <= ONE_CYCLE ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: random fetches against a word-array model.
// Two instances: LATENCY=2 (main) and LATENCY=1 (streaming).
module tb_imem_responder;

  localparam int          DW  = 256;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_instr, resp_addr;

  logic        q1_req_valid, q1_req_ready;
  logic [31:0] q1_req_addr;
  logic        q1_resp_valid, q1_resp_ready, q1_resp_err;
  logic [31:0] q1_resp_instr, q1_resp_addr;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mm [DW];

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH_WORDS(DW), .LATENCY(2), .NOP_WORD(NOP)
  ) u_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_addr(resp_addr),
    .resp_err(resp_err),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  imem_responder #(
    .DEPTH_WORDS(DW), .LATENCY(1), .NOP_WORD(NOP)
  ) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(q1_req_valid), .req_ready(q1_req_ready),
    .req_addr(q1_req_addr),
    .resp_valid(q1_resp_valid), .resp_ready(q1_resp_ready),
    .resp_instr(q1_resp_instr), .resp_addr(q1_resp_addr),
    .resp_err(q1_resp_err),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // {err, instr} a correct fetch of byte address a returns.
  function automatic logic [32:0] model(input logic [31:0] a);
    if (a[1:0] != 2'b00 || (a / 4) >= DW)
      return {1'b1, NOP};
    return {1'b0, mm[a / 4]};
  endfunction

  function automatic void model_wr(input logic [31:0] a,
                                   input logic [31:0] d);
    if ((a / 4) < DW)
      mm[a / 4] = d;
  endfunction

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    model_wr(a, d);
  endtask

  task automatic fetch(input logic [31:0] a,
                       input int hold,
                       input bit race,
                       input logic [31:0] rdata);
    logic [32:0] e;
    int          cyc;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e   = model(a);
    cyc = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      if (race && cyc == 1) begin
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = rdata;
      end else begin
        prog_we = 1'b0;
      end
    end while (!resp_valid && cyc < 20);
    if (race)
      model_wr(a, rdata);
    check("latency", 32'(cyc), 32'd2);
    check("instr", resp_instr, e[31:0]);
    check("err", 32'(resp_err), 32'(e[32]));
    check("addr", resp_addr, a);
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_instr", resp_instr, e[31:0]);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hs_valid", 32'(resp_valid), 32'd0);
    check("hs_ready", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] list [$];
  logic [32:0] e;
  logic [31:0] a;
  bit          seen;
  int          idx, got, last, kind;

  initial begin
    reset         = 1'b1;
    prog_we       = 1'b0;
    prog_addr     = '0;
    prog_data     = '0;
    req_valid     = 1'b0;
    req_addr      = '0;
    resp_ready    = 1'b0;
    q1_req_valid  = 1'b0;
    q1_req_addr   = '0;
    q1_resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_q1_ready", 32'(q1_req_ready), 32'd0);

    // Fill memory while reset is held; low bits are junk.
    for (int i = 0; i < DW; i++)
      load(32'(i * 4) | 32'($urandom_range(0, 3)), $urandom);
    load(32'h0, 32'h00500093);
    load(32'h4, 32'h00108133);
    load(32'h8, 32'hAAAAAAAA);
    load(32'h400, 32'hDEADBEEF);
    load(32'hFFFFFFFC, 32'hCAFEF00D);
    @(negedge clk);
    prog_we = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check("rst_instr", resp_instr, 32'h0);
    check("rst_addr", resp_addr, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);

    fetch(32'h4, 0, 1'b0, '0);
    check("plan_w4", resp_instr, 32'h00108133);
    fetch(32'h0, 5, 1'b0, '0);
    check("plan_w0", resp_instr, 32'h00500093);
    fetch(32'h2, 0, 1'b0, '0);
    fetch(32'h400, 1, 1'b0, '0);
    fetch(32'hFFFFFFFC, 0, 1'b0, '0);
    fetch(32'h8, 0, 1'b1, 32'hBBBBBBBB);
    check("race_old", resp_instr, 32'hAAAAAAAA);
    fetch(32'h8, 0, 1'b0, '0);
    check("race_new", resp_instr, 32'hBBBBBBBB);

    // Reset while a fetch sits in its wait cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    seen      = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= resp_valid;
      check("midrst_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    check("midrst_idle", 32'(req_ready), 32'd1);
    fetch(32'h0, 0, 1'b0, '0);
    check("midrst_mem", resp_instr, 32'h00500093);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)
        a = 32'($urandom_range(0, DW - 1)) * 4;
      else if (kind == 6)
        a = ($urandom & 32'hFFFF_FFFC) |
            32'($urandom_range(1, 3));
      else if (kind == 7)
        a = 32'(DW * 4) + (($urandom % 32'h1000) & ~32'h3);
      else if (kind == 8)
        a = 32'hFFFFFFFC;
      else begin
        load($urandom & 32'h7FF, $urandom);
        @(negedge clk);
        prog_we = 1'b0;
        a = 32'($urandom_range(0, DW - 1)) * 4;
      end
      fetch(a, $urandom_range(0, 3), 1'b0, '0);
    end

    // Streaming on the single-cycle instance.
    list.push_back(32'h0);
    list.push_back(32'h4);
    list.push_back(32'h8);
    for (int n = 0; n < 5; n++)
      list.push_back(32'($urandom_range(0, DW - 1)) * 4);
    list.push_back(32'h6);
    idx  = 0;
    got  = 0;
    last = 0;
    for (int c = 0; c < 80 && got < list.size(); c++) begin
      @(negedge clk);
      if (q1_resp_valid) begin
        e = model(list[got]);
        check("s_addr", q1_resp_addr, list[got]);
        check("s_instr", q1_resp_instr, e[31:0]);
        check("s_err", 32'(q1_resp_err), 32'(e[32]));
        if (got > 0)
          check("s_gap", 32'(c - last), 32'd2);
        last = c;
        got++;
      end
      if (idx < list.size()) begin
        q1_req_valid = 1'b1;
        q1_req_addr  = list[idx];
        if (q1_req_ready)
          idx++;
      end else begin
        q1_req_valid = 1'b0;
      end
    end
    q1_req_valid = 1'b0;
    check("s_count", 32'(got), 32'(list.size()));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch path. Accepts word-fetch requests carrying the current PC, returns the 32-bit instruction after a fixed latency, and reports out-of-range or misaligned fetches.
- Sits between the PC register and the decode stage.
- Includes a program-load write port used by the bench and the boot loader to fill memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words; power of two, >= 4.
- LATENCY, 2, clock edges from request acceptance to resp_valid assertion; >= 1.
- NOP_WORD, 32'h00000013, instruction returned on an error response (addi x0,x0,0).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address (PC) of the fetch.
- resp_valid  output  1  response word valid.
- resp_ready  input  1  consumer accepts the response.
- resp_instr  output  32  fetched instruction, or NOP_WORD on error.
- resp_addr  output  32  echo of the accepted req_addr.
- resp_err  output  1  fetch was misaligned or out of range.
- prog_we  input  1  program-load write enable.
- prog_addr  input  32  byte address of the load; bits [1:0] ignored.
- prog_data  input  32  word to write.

Behaviour:
- Reset: synchronous, active-high; clk/reset exactly as named above. In the cycle after reset is sampled high:
  - state=IDLE.
  - resp_valid=0; resp_instr, resp_addr, resp_err = 0.
  - Latency counter = 0.
  - Memory contents are not cleared.
  - req_ready = (state==IDLE) && !reset, so it is 0 while reset is held.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch req_addr, compute error flags, load counter with LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- WAIT:
  - req_ready=0. Counter decrements each edge.
  - When the counter is 1 at an edge, the next state is RESP.
  - Total: resp_valid rises exactly LATENCY edges after the accepting edge.
- Data capture: resp_instr/resp_err/resp_addr are registered on the edge that enters RESP.
  - Memory is read at that edge.
  - A prog_we write on that same edge to the same word is NOT visible (old data returned). Writes on any earlier edge are visible.
- RESP:
  - resp_valid=1; resp_instr/resp_addr/resp_err held stable until resp_valid && resp_ready.
  - On handshake: resp_valid drops, state returns to IDLE. req_ready is 1 the following cycle; no same-cycle re-accept.
  - Minimum request spacing is LATENCY+1 cycles.
  - Back-pressure (resp_ready=0) holds RESP indefinitely.
- Error rules, evaluated on the latched address:
  - misaligned = addr[1:0] != 0.
  - out_of_range = addr[31:2] >= DEPTH_WORDS.
  - resp_err = misaligned || out_of_range; when set, resp_instr = NOP_WORD and the memory is not indexed.
  - Otherwise resp_instr = mem[addr[31:2]].
- Address 32'hFFFFFFFC: out of range, no wrap-around into low memory.
- Program port:
  - Writes occur on any edge with prog_we=1, in any state, including during reset.
  - An out-of-range prog_addr is silently dropped.
  - No handshake; single-cycle write.
- Reset mid-operation: an in-flight request in WAIT or RESP is discarded without a response. The FSM is in IDLE in the next cycle.
- req_valid while not ready: ignored. The requester must hold it until the handshake.

Test Plan:
1. Load: prog_we words 0x00500093 @0x0 and 0x00108133 @0x4. Request 0x4 with LATENCY=2 → resp_valid exactly 2 edges after accept; resp_instr=0x00108133, resp_addr=0x4, resp_err=0.
2. Back-pressure: request 0x0, hold resp_ready=0 for 5 cycles → resp_valid stays 1 with resp_instr=0x00500093 stable and req_ready=0. Raise resp_ready → IDLE next cycle, req_ready=1.
3. Errors:
   - Request 0x2 → resp_err=1, resp_instr=0x00000013.
   - Request 0x400 (DEPTH_WORDS=256) → resp_err=1, resp_instr=0x00000013.
   - Request 0xFFFFFFFC → resp_err=1, no aliasing.
4. Write/read race: request 0x8 (holds 0xAAAAAAAA). On the edge entering RESP, write 0xBBBBBBBB @0x8 → response 0xAAAAAAAA. A second fetch of 0x8 returns 0xBBBBBBBB.
5. Reset mid-operation: accept request, assert reset in WAIT → no resp_valid ever issued for it. After deassert req_ready=1, memory intact, a new fetch of 0x0 returns 0x00500093.
6. Throughput with LATENCY=1 and resp_ready tied 1: streaming requests 0x0, 0x4, 0x8 → one response every 2 cycles, in order, addresses echoed correctly.
